// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM sequencing over a shared datapath,
// with illegal-instruction detection, memory-timeout traps and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned INSTRET_W    = 32,
    parameter bit          FENCE_AS_NOP = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [31:0]          i_instr,
    input  logic                 i_br_less,
    input  logic                 i_br_equal,
    input  logic                 i_imem_ack,
    input  logic                 i_dmem_ack,
    output logic                 o_imem_req,
    output logic                 o_ir_wren,
    output logic                 o_dmem_req,
    output logic                 o_mem_wren,
    output logic                 o_pc_wren,
    output logic                 o_pc_sel,
    output logic                 o_rd_wren,
    output logic                 o_br_un,
    output logic                 o_opa_sel,
    output logic                 o_opb_sel,
    output logic [3:0]           o_alu_op,
    output logic [1:0]           o_wb_sel,
    output logic                 o_retire,
    output logic [INSTRET_W-1:0] o_instret,
    output logic                 o_trap,
    output logic [1:0]           o_trap_cause
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 2);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StTrap} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [INSTRET_W-1:0] instret_q;
    logic                 trap_q, trap_set;
    logic [1:0]           cause_q, cause_d;

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal, is_system, timeout_hit;
    logic [3:0] alu_dec;
    logic       unused_bits;

    assign opcode      = i_instr[6:2];
    assign funct3      = i_instr[14:12];
    assign funct7      = i_instr[31:25];
    assign unused_bits = ^{i_instr[24:15], i_instr[11:7]};
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));

    always_comb begin
        illegal   = 1'b0;
        is_system = 1'b0;
        if (i_instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD:   illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
                OPC_STORE:  illegal = (funct3 > 3'b010);
                OPC_BRANCH: illegal = (funct3[2:1] == 2'b01);
                OPC_JALR:   illegal = (funct3 != 3'b000);
                OPC_OP:     illegal = !((funct7 == 7'b0000000) ||
                                        ((funct7 == 7'b0100000) &&
                                         ((funct3 == 3'b000) || (funct3 == 3'b101))));
                OPC_OPIMM: begin
                    if (funct3 == 3'b001) begin
                        illegal = (funct7 != 7'b0000000);
                    end else if (funct3 == 3'b101) begin
                        illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                end
                OPC_FENCE:  illegal = !FENCE_AS_NOP;
                OPC_LUI, OPC_AUIPC, OPC_JAL: illegal = 1'b0;
                OPC_SYSTEM: is_system = 1'b1;
                default:    illegal = 1'b1;
            endcase
        end
    end

    // funct7[5] selects SUB only for register-register ops; for immediates it is imm data.
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    end

    always_comb begin
        o_imem_req = 1'b0;
        o_ir_wren  = 1'b0;
        o_dmem_req = 1'b0;
        o_mem_wren = 1'b0;
        o_pc_wren  = 1'b0;
        o_pc_sel   = 1'b0;
        o_rd_wren  = 1'b0;
        o_br_un    = 1'b0;
        o_opa_sel  = 1'b0;
        o_opb_sel  = 1'b1;
        o_alu_op   = ALU_ADD;
        o_wb_sel   = 2'b00;
        o_retire   = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        trap_set   = 1'b0;
        cause_d    = cause_q;

        case (state_q)
            StFetch: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    o_ir_wren = 1'b1;
                    state_d   = StDecode;
                    cnt_d     = '0;
                end else if (timeout_hit) begin
                    state_d  = StTrap;
                    trap_set = 1'b1;
                    cause_d  = 2'b01;
                end else if (MEM_TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDecode: begin
                if (illegal) begin
                    state_d  = StTrap;
                    trap_set = 1'b1;
                    cause_d  = 2'b00;
                end else if (is_system) begin
                    state_d  = StTrap;
                    trap_set = 1'b1;
                    cause_d  = 2'b11;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                cnt_d   = '0;
                case (opcode)
                    OPC_OP, OPC_OPIMM: begin
                        o_opb_sel = (opcode == OPC_OPIMM);
                        o_alu_op  = alu_dec;
                        o_rd_wren = 1'b1;
                        o_pc_wren = 1'b1;
                        o_retire  = 1'b1;
                    end
                    OPC_LUI, OPC_AUIPC: begin
                        o_opa_sel = (opcode == OPC_AUIPC);
                        o_wb_sel  = (opcode == OPC_LUI) ? 2'b11 : 2'b00;
                        o_rd_wren = 1'b1;
                        o_pc_wren = 1'b1;
                        o_retire  = 1'b1;
                    end
                    OPC_JAL, OPC_JALR: begin
                        o_opa_sel = (opcode == OPC_JAL);
                        o_pc_sel  = 1'b1;
                        o_wb_sel  = 2'b10;
                        o_rd_wren = 1'b1;
                        o_pc_wren = 1'b1;
                        o_retire  = 1'b1;
                    end
                    OPC_BRANCH: begin
                        o_opa_sel = 1'b1;
                        o_br_un   = funct3[1];
                        o_pc_wren = 1'b1;
                        o_retire  = 1'b1;
                        case (funct3)
                            3'b000:         o_pc_sel = i_br_equal;
                            3'b001:         o_pc_sel = !i_br_equal;
                            3'b100, 3'b110: o_pc_sel = i_br_less;
                            3'b101, 3'b111: o_pc_sel = !i_br_less;
                            default:        o_pc_sel = 1'b0;
                        endcase
                    end
                    OPC_FENCE: begin
                        o_pc_wren = 1'b1;
                        o_retire  = 1'b1;
                    end
                    OPC_LOAD, OPC_STORE: state_d = StMem;
                    default: ;
                endcase
            end
            StMem: begin
                o_dmem_req = 1'b1;
                o_mem_wren = (opcode == OPC_STORE);
                if (i_dmem_ack) begin
                    if (opcode == OPC_LOAD) begin
                        o_rd_wren = 1'b1;
                        o_wb_sel  = 2'b01;
                    end
                    o_pc_wren = 1'b1;
                    o_retire  = 1'b1;
                    state_d   = StFetch;
                    cnt_d     = '0;
                end else if (timeout_hit) begin
                    state_d  = StTrap;
                    trap_set = 1'b1;
                    cause_d  = 2'b10;
                end else if (MEM_TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTrap: ;
            default: state_d = StFetch;
        endcase

        // Held reset silences every combinational control so nothing is written mid-abort.
        if (!i_rst_n) begin
            o_imem_req = 1'b0;
            o_ir_wren  = 1'b0;
            o_dmem_req = 1'b0;
            o_mem_wren = 1'b0;
            o_pc_wren  = 1'b0;
            o_pc_sel   = 1'b0;
            o_rd_wren  = 1'b0;
            o_br_un    = 1'b0;
            o_opa_sel  = 1'b0;
            o_opb_sel  = 1'b0;
            o_alu_op   = 4'b0000;
            o_wb_sel   = 2'b00;
            o_retire   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            if (o_retire) instret_q <= instret_q + 1'b1;
            if (trap_set) trap_q <= 1'b1;
        end
    end

    assign o_instret    = instret_q;
    assign o_trap       = trap_q;
    assign o_trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instruction streams checked cycle by cycle
// against an instruction-level model of the control outputs.
module tb_multicycle_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   instr;
    logic          br_less, br_equal, imem_ack, dmem_ack;
    logic          imem_req, ir_wren, dmem_req, mem_wren, pc_wren, pc_sel, rd_wren, br_un;
    logic          opa_sel, opb_sel, retire, trap;
    logic [3:0]    alu_op;
    logic [1:0]    wb_sel, trap_cause;
    logic [IW-1:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .INSTRET_W(IW), .FENCE_AS_NOP(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_br_less(br_less),
        .i_br_equal(br_equal), .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack),
        .o_imem_req(imem_req), .o_ir_wren(ir_wren), .o_dmem_req(dmem_req),
        .o_mem_wren(mem_wren), .o_pc_wren(pc_wren), .o_pc_sel(pc_sel), .o_rd_wren(rd_wren),
        .o_br_un(br_un), .o_opa_sel(opa_sel), .o_opb_sel(opb_sel), .o_alu_op(alu_op),
        .o_wb_sel(wb_sel), .o_retire(retire), .o_instret(instret), .o_trap(trap),
        .o_trap_cause(trap_cause)
    );

    typedef struct packed {
        logic       imem_req, ir_wren, dmem_req, mem_wren, pc_wren, pc_sel, rd_wren, br_un;
        logic       opa_sel, opb_sel;
        logic [3:0] alu_op;
        logic [1:0] wb_sel;
        logic       retire;
    } outs_t;

    typedef enum {C_ILL, C_SYS, C_R, C_I, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LOAD,
                  C_STORE, C_FENCE} cls_t;

    outs_t         obs;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [IW-1:0] model_ir = '0;
    logic          model_trap = 1'b0;
    logic [1:0]    model_cause = 2'b00;

    assign obs = {imem_req, ir_wren, dmem_req, mem_wren, pc_wren, pc_sel, rd_wren, br_un,
                  opa_sel, opb_sel, alu_op, wb_sel, retire};

    function automatic cls_t classify(logic [31:0] w);
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        if (w[1:0] != 2'b11) return C_ILL;
        case (w[6:0])
            7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? C_LOAD : C_ILL;
            7'h23: return (f3 <= 3'd2) ? C_STORE : C_ILL;
            7'h63: return (f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7}) ? C_BR : C_ILL;
            7'h67: return (f3 == 3'd0) ? C_JALR : C_ILL;
            7'h6F: return C_JAL;
            7'h37: return C_LUI;
            7'h17: return C_AUIPC;
            7'h73: return C_SYS;
            7'h0F: return C_FENCE;
            7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
                          ? C_R : C_ILL;
            7'h13: begin
                if (f3 == 3'd1) return (f7 == 7'h00) ? C_I : C_ILL;
                if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? C_I : C_ILL;
                return C_I;
            end
            default: return C_ILL;
        endcase
    endfunction

    function automatic outs_t dflt();
        outs_t o = '0;
        o.opb_sel = 1'b1;
        return o;
    endfunction

    function automatic logic [3:0] alu_of(logic [2:0] f3, logic f75, logic is_r);
        logic [3:0] tbl [8] = '{4'h0, 4'h7, 4'h2, 4'h3, 4'h4, 4'h8, 4'h5, 4'h6};
        if (f3 == 3'd0 && is_r && f75) return 4'h1;
        if (f3 == 3'd5 && f75) return 4'h9;
        return tbl[f3];
    endfunction

    function automatic outs_t exp_exec(logic [31:0] w, logic eq, logic less);
        outs_t      o  = dflt();
        logic [2:0] f3 = w[14:12];
        cls_t       c  = classify(w);
        if (c inside {C_R, C_I, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_FENCE}) begin
            o.pc_wren = 1'b1;
            o.retire  = 1'b1;
        end
        case (c)
            C_R:     begin o.opb_sel = 1'b0; o.alu_op = alu_of(f3, w[30], 1'b1); o.rd_wren = 1'b1; end
            C_I:     begin o.alu_op = alu_of(f3, w[30], 1'b0); o.rd_wren = 1'b1; end
            C_LUI:   begin o.wb_sel = 2'b11; o.rd_wren = 1'b1; end
            C_AUIPC: begin o.opa_sel = 1'b1; o.rd_wren = 1'b1; end
            C_JAL:   begin o.opa_sel = 1'b1; o.pc_sel = 1'b1; o.wb_sel = 2'b10; o.rd_wren = 1'b1; end
            C_JALR:  begin o.pc_sel = 1'b1; o.wb_sel = 2'b10; o.rd_wren = 1'b1; end
            C_BR: begin
                o.opa_sel = 1'b1;
                o.br_un   = f3[1];
                if (f3 == 3'd0)      o.pc_sel = eq;
                else if (f3 == 3'd1) o.pc_sel = !eq;
                else                 o.pc_sel = f3[0] ? !less : less;
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check_all(input string tag, input outs_t e);
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s outputs: got %h want %h", tag, obs, e);
        end
        n_checks++;
        assert (instret === model_ir) else begin
            n_fail++;
            $error("FAIL %s instret: got %0d want %0d", tag, instret, model_ir);
        end
        n_checks++;
        assert ({trap, trap_cause} === {model_trap, model_cause}) else begin
            n_fail++;
            $error("FAIL %s trap/cause: got %b/%b want %b/%b", tag, trap, trap_cause,
                   model_trap, model_cause);
        end
    endtask

    // Called just after a negedge with inputs driven; samples well clear of both edges.
    task automatic cycle_check(input string tag, input outs_t e);
        #2;
        check_all(tag, e);
        #1;
    endtask

    task automatic rand_side();
        br_equal = 1'($urandom);
        br_less  = 1'($urandom);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        instr    = $urandom;
        #1;
        model_ir    = '0;
        model_trap  = 1'b0;
        model_cause = 2'b00;
        check_all("reset_async", '0);
        repeat (2) begin
            @(negedge clk);
            cycle_check("reset_hold", '0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic trap_cycles(input logic [1:0] cause);
        model_trap  = 1'b1;
        model_cause = cause;
        repeat (2) begin
            @(negedge clk);
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            instr    = $urandom;
            rand_side();
            cycle_check("trap", dflt());
        end
    endtask

    task automatic fetch_timeout();
        outs_t e = dflt();
        e.imem_req = 1'b1;
        for (int w = 0; w <= int'(TO); w++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            instr    = $urandom;
            cycle_check("fetch_wait", e);
        end
        trap_cycles(2'b01);
    endtask

    task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input logic eq,
                             input logic less, input bit abort_mem, output bit trapped);
        cls_t  c = classify(w);
        outs_t e;
        trapped = 1'b0;
        for (int k = 0; k <= fw; k++) begin
            @(negedge clk);
            imem_ack = (k == fw);
            dmem_ack = 1'($urandom);
            instr    = $urandom;
            rand_side();
            e = dflt();
            e.imem_req = 1'b1;
            e.ir_wren  = (k == fw);
            cycle_check("fetch", e);
        end
        @(negedge clk);
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        instr    = w;
        cycle_check("decode", dflt());
        if (c == C_ILL || c == C_SYS) begin
            trap_cycles((c == C_ILL) ? 2'b00 : 2'b11);
            trapped = 1'b1;
            return;
        end
        @(negedge clk);
        br_equal = eq;
        br_less  = less;
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        e = exp_exec(w, eq, less);
        cycle_check("exec", e);
        if (e.retire) model_ir = model_ir + 1'b1;
        if (c != C_LOAD && c != C_STORE) return;
        for (int k = 0; k <= mw && k <= int'(TO); k++) begin
            @(negedge clk);
            dmem_ack = (k == mw);
            imem_ack = 1'($urandom);
            rand_side();
            e = dflt();
            e.dmem_req = 1'b1;
            e.mem_wren = (c == C_STORE);
            if (k == mw) begin
                e.pc_wren = 1'b1;
                e.retire  = 1'b1;
                if (c == C_LOAD) begin
                    e.rd_wren = 1'b1;
                    e.wb_sel  = 2'b01;
                end
            end
            cycle_check("mem", e);
            if (k == mw) model_ir = model_ir + 1'b1;
            if (abort_mem) begin
                do_reset();
                return;
            end
        end
        if (mw > int'(TO)) begin
            trap_cycles(2'b10);
            trapped = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int          k = $urandom_range(0, 19);
        if (k == 19) return 32'h0000_0073;
        if (k == 18) return w;
        case (k % 9)
            0: begin w[6:0] = 7'h33; if (w[8]) w[31:25] = {1'b0, w[30], 5'b0}; end
            1: begin w[6:0] = 7'h13; if (w[8]) w[31:25] = {1'b0, w[30], 5'b0}; end
            2: w[6:0] = w[8] ? 7'h37 : 7'h17;
            3: w[6:0] = 7'h6F;
            4: begin w[6:0] = 7'h67; if (w[9]) w[14:12] = 3'd0; end
            5: w[6:0] = 7'h63;
            6: w[6:0] = 7'h03;
            7: w[6:0] = 7'h23;
            default: w[6:0] = 7'h0F;
        endcase
        return w;
    endfunction

    typedef struct {
        logic [31:0] w;
        int          fw, mw;
        logic        eq, less;
    } step_t;

    initial begin
        step_t dir [] = '{
            '{32'h0020_81B3, 0, 0, 1'b0, 1'b0},  // ADD
            '{32'h4020_81B3, 1, 0, 1'b0, 1'b0},  // SUB
            '{32'h0020_8463, 0, 0, 1'b1, 1'b0},  // BEQ taken
            '{32'h0020_8463, 2, 0, 1'b0, 1'b1},  // BEQ not taken
            '{32'h0020_E463, 0, 0, 1'b0, 1'b1},  // BLTU
            '{32'h0020_D463, 0, 0, 1'b0, 1'b1},  // BGE
            '{32'h0000_A183, 0, 3, 1'b0, 1'b0},  // LW, ack after 3 waits
            '{32'h0030_A023, 0, 0, 1'b0, 1'b0},  // SW
            '{32'h0000_A183, TO, TO, 1'b0, 1'b0}, // acks on the last allowed cycle
            '{32'h1234_50B7, 0, 0, 1'b0, 1'b0},  // LUI
            '{32'h0000_1097, 0, 0, 1'b0, 1'b0},  // AUIPC
            '{32'h0080_00EF, 0, 0, 1'b0, 1'b0},  // JAL
            '{32'h0000_80E7, 0, 0, 1'b0, 1'b0},  // JALR
            '{32'h0FF0_000F, 0, 0, 1'b0, 1'b0},  // FENCE
            '{32'hFFF0_8093, 0, 0, 1'b0, 1'b0},  // ADDI with negative imm
            '{32'h4010_D093, 0, 0, 1'b0, 1'b0},  // SRAI
            '{32'h0010_B093, 0, 0, 1'b0, 1'b0}   // SLTIU
        };
        logic [31:0] bad [] = '{32'h0000_0000, 32'h0000_0073, 32'h0010_0073, 32'h0020_A463,
                                32'h0000_B183, 32'h0030_B023, 32'h0000_90E7, 32'h0220_81B3,
                                32'h4010_9093, 32'h4020_91B3, 32'h8010_D093, 32'h0000_007F};
        bit trapped;

        rst_n    = 1'b0;
        instr    = '0;
        br_less  = 1'b0;
        br_equal = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        do_reset();

        foreach (dir[i]) begin
            run_instr(dir[i].w, dir[i].fw, dir[i].mw, dir[i].eq, dir[i].less, 1'b0, trapped);
        end
        for (int i = 0; i < 18; i++) begin  // enough retires to wrap the counter
            run_instr(32'h0010_8093, 0, 0, 1'b0, 1'b0, 1'b0, trapped);
        end

        foreach (bad[i]) begin
            run_instr(bad[i], 0, 0, 1'b0, 1'b0, 1'b0, trapped);
            n_checks++;
            assert (trapped === 1'b1) else begin
                n_fail++;
                $error("FAIL illegal_class %h: got %b want 1", bad[i], trapped);
            end
            do_reset();
        end

        fetch_timeout();
        do_reset();
        run_instr(32'h0000_A183, 0, TO + 1, 1'b0, 1'b0, 1'b0, trapped);
        do_reset();

        run_instr(32'h0000_A183, 0, 2, 1'b0, 1'b0, 1'b1, trapped);
        run_instr(32'h0020_81B3, 0, 0, 1'b0, 1'b0, 1'b0, trapped);

        for (int i = 0; i < 80; i++) begin
            run_instr(rand_instr(), $urandom_range(0, TO), $urandom_range(0, TO),
                      1'($urandom), 1'($urandom), 1'b0, trapped);
            if (trapped) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle successor of the RV32I single-cycle control unit: FSM sequencing FETCH/DECODE/EXEC/MEM over a shared datapath, with ready/ack handshakes to instruction and data memory.
- Adds illegal-instruction detection, memory-timeout traps, and a retired-instruction counter.
- Sits between the instruction register (IR), the ALU, the branch comparator, the LSU and the PC register.
- Reuses the existing alu_op and wb_sel encodings unchanged.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles for an imem/dmem ack before a trap; 0 disables timeouts.
- INSTRET_W, 32: width of the retired-instruction counter.
- FENCE_AS_NOP, 1: 1 = FENCE retires as a NOP; 0 = FENCE is illegal.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_instr  in  32  IR contents (instruction latched on o_ir_wren).
- i_br_less  in  1  comparator: rs1 < rs2 (signedness per o_br_un).
- i_br_equal  in  1  comparator: rs1 == rs2.
- i_imem_ack  in  1  instruction word valid this cycle.
- i_dmem_ack  in  1  data access complete this cycle.
- o_imem_req  out  1  instruction fetch request.
- o_ir_wren  out  1  latch the imem word into the IR.
- o_dmem_req  out  1  data access request.
- o_mem_wren  out  1  data access is a store.
- o_pc_wren  out  1  update the PC this cycle.
- o_pc_sel  out  1  0 = PC+4, 1 = ALU result.
- o_rd_wren  out  1  register-file write enable.
- o_br_un  out  1  1 = unsigned compare.
- o_opa_sel  out  1  0 = rs1, 1 = PC.
- o_opb_sel  out  1  0 = rs2, 1 = imm.
- o_alu_op  out  4  0000 ADD, 0001 SUB, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 OR, 0110 AND, 0111 SLL, 1000 SRL, 1001 SRA.
- o_wb_sel  out  2  00 ALU, 01 LSU, 10 PC+4, 11 imm.
- o_retire  out  1  one-cycle pulse when an instruction completes.
- o_instret  out  INSTRET_W  retired-instruction count.
- o_trap  out  1  sticky trap flag.
- o_trap_cause  out  2  00 illegal, 01 imem timeout, 10 dmem timeout, 11 ECALL/EBREAK.

Behaviour:
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_TRAP. State register, wait counter, o_instret, o_trap and o_trap_cause are flops; all other outputs are combinational from state, i_instr and inputs.
- Reset (i_rst_n low, async):
  - state = S_FETCH, counters = 0, o_trap = 0, o_trap_cause = 00.
  - All outputs forced to 0 while reset is held.
  - First o_imem_req is asserted in the cycle after reset release.
  - Reset mid-operation (any state) aborts with no retire and no further writes.
- Defaults in every state: o_opb_sel = 1, o_alu_op = ADD, o_wb_sel = 00; every other output 0.
- S_FETCH:
  - o_imem_req = 1.
  - On i_imem_ack: o_ir_wren = 1, go to S_DECODE, clear the counter.
  - Otherwise the counter increments. When counter == MEM_TIMEOUT (and MEM_TIMEOUT != 0): go to S_TRAP, cause 01.
- S_DECODE (1 cycle): classify i_instr.
  - Illegal, go to S_TRAP with cause 00:
    - i_instr[1:0] != 11;
    - unknown opcode[6:2];
    - branch funct3 010 or 011;
    - load funct3 011, 110 or 111;
    - store funct3 > 010;
    - JALR funct3 != 0;
    - R-type funct7 not 0000000, or 0100000 with funct3 other than 000/101;
    - SLLI with funct7 != 0;
    - SRLI/SRAI with funct7 not 0000000/0100000;
    - FENCE when FENCE_AS_NOP = 0.
  - SYSTEM opcode: go to S_TRAP with cause 11.
  - Otherwise go to S_EXEC.
- S_EXEC (1 cycle):
  - R-type: o_opb_sel = 0, ALU op from funct3/funct7[5].
  - OP-IMM: same decode with imm operand; funct7[5] is used only for shifts.
  - rd_wren/pc_wren/retire:
    - R-type, OP-IMM: o_rd_wren = 1, o_pc_wren = 1, o_retire = 1.
    - LUI: o_wb_sel = 11, o_rd_wren = 1, o_pc_wren = 1, o_retire = 1.
    - AUIPC: o_opa_sel = 1, o_wb_sel = 00, o_rd_wren = 1, o_pc_wren = 1, o_retire = 1.
    - JAL: o_opa_sel = 1, o_pc_sel = 1, o_wb_sel = 10, o_rd_wren = 1, o_pc_wren = 1, o_retire = 1.
    - JALR: o_opa_sel = 0, o_pc_sel = 1, o_wb_sel = 10, o_rd_wren = 1, o_pc_wren = 1, o_retire = 1. The datapath clears target bit 0.
    - Branch: o_opa_sel = 1, o_br_un = funct3[1], o_pc_wren = 1, o_retire = 1, o_rd_wren = 0.
      - o_pc_sel: BEQ = eq, BNE = !eq, BLT/BLTU = less, BGE/BGEU = !less.
    - FENCE (NOP): o_pc_wren = 1, o_retire = 1, nothing else.
  - Next state: S_FETCH after all of the above. Load/store: ADD address, go to S_MEM, no retire.
- S_MEM:
  - Hold the address controls (o_opa_sel = 0, o_opb_sel = 1, ADD); o_dmem_req = 1.
  - o_mem_wren = 1 for stores.
  - On i_dmem_ack:
    - Load: o_rd_wren = 1, o_wb_sel = 01.
    - Both: o_pc_wren = 1, o_retire = 1, go to S_FETCH.
  - Timeout rules as in S_FETCH, with cause 10.
- S_TRAP: o_trap = 1 and cause held; all request/write enables 0; exit only by reset.
- o_instret increments by 1 on every o_retire and wraps modulo 2^INSTRET_W.
- A late ack arriving in the same cycle the counter reaches MEM_TIMEOUT: the ack wins, no trap.
- Latency with immediate ack: ALU/branch/jump take 3 cycles per instruction; load/store take 4.

Test Plan:
- Reset, then ADD 0x002081B3 with imem ack every fetch:
  - FETCH → DECODE → EXEC.
  - In EXEC: o_alu_op = 0000, o_opb_sel = 0, o_rd_wren = 1, o_retire = 1.
  - o_instret = 1 after the first retire; SUB 0x402081B3 then gives o_alu_op = 0001.
- BEQ 0x00208463:
  - With i_br_equal = 1: EXEC shows o_pc_sel = 1, o_opa_sel = 1, o_rd_wren = 0.
  - With i_br_equal = 0: o_pc_sel = 0. BLTU 0x0020E463 gives o_br_un = 1.
- LW 0x0000A183 with dmem ack after 3 cycles:
  - S_MEM is held 3 cycles with o_dmem_req = 1, o_mem_wren = 0.
  - On ack: o_rd_wren = 1, o_wb_sel = 01, o_retire = 1.
  - SW 0x0030A023 gives o_mem_wren = 1 and no rd write.
- MEM_TIMEOUT = 4, imem never acks: o_trap = 1, cause 01, and o_imem_req drops 0 from then on.
- Illegal 0x00000000 → trap cause 00. ECALL 0x00000073 → trap cause 11. No o_retire in either case.
- Reset asserted mid-S_MEM: outputs go to 0 immediately, o_instret = 0, and a normal FETCH follows release.
